// File: rtl/trace_wb_checker.sv
// Write-back trace checker: compares CPU register commits against a golden trace held in a FIFO.
// Define TRACE_CHK_TIMEOUT_EN to add PC-stall detection (fail_cause 2'b11).
module trace_wb_checker #(
  parameter int unsigned DEPTH   = 16,
  parameter logic [31:0] END_PC  = 32'h1c00_0100,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] debug_wb_pc,
  input  logic [3:0]  debug_wb_rf_we,
  input  logic [4:0]  debug_wb_rf_wnum,
  input  logic [31:0] debug_wb_rf_wdata,
  input  logic        ref_valid,
  output logic        ref_ready,
  input  logic [31:0] ref_pc,
  input  logic [4:0]  ref_wnum,
  input  logic [31:0] ref_wdata,
  output logic        done,
  output logic        pass,
  output logic [1:0]  fail_cause,
  output logic [31:0] err_pc,
  output logic [31:0] err_ref_pc,
  output logic [31:0] err_ref_wdata,
  output logic [31:0] err_wdata,
  output logic [31:0] commit_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } ref_entry_t;

  typedef enum logic [1:0] {ST_RUN, ST_PASS, ST_FAIL} state_t;

  state_t        state, state_next;
  ref_entry_t    mem [DEPTH];
  ref_entry_t    head;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          empty, full, push, pop;
  logic          commit, underrun, mismatch, timeout_hit;
  logic [31:0]   we_mask;

  logic        done_next, pass_next;
  logic [1:0]  fail_cause_next;
  logic [31:0] err_pc_next, err_ref_pc_next, err_ref_wdata_next, err_wdata_next, commit_cnt_next;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign ref_ready = (state == ST_RUN) && !full;
  assign push      = ref_valid && ref_ready;
  assign head      = mem[rd_ptr];

  assign commit   = (state == ST_RUN) && (debug_wb_rf_we != 4'd0) && (debug_wb_rf_wnum != 5'd0);
  assign pop      = commit && !empty;
  assign underrun = commit && empty;
  assign we_mask  = {{8{debug_wb_rf_we[3]}}, {8{debug_wb_rf_we[2]}},
                     {8{debug_wb_rf_we[1]}}, {8{debug_wb_rf_we[0]}}};
  // Only bytes actually written by the core take part in the data compare.
  assign mismatch = pop && ((head.pc != debug_wb_pc) || (head.wnum != debug_wb_rf_wnum) ||
                            (((head.wdata ^ debug_wb_rf_wdata) & we_mask) != 32'd0));

  // Golden FIFO storage; contents need no reset, only the pointers do.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{pc: ref_pc, wnum: ref_wnum, wdata: ref_wdata};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

`ifdef TRACE_CHK_TIMEOUT_EN
  localparam int unsigned SW = $clog2(TIMEOUT + 1);
  logic [SW-1:0] stall_cnt;
  logic [31:0]   prev_pc;

  // Counts consecutive edges on which the write-back PC has not moved.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt <= '0;
      prev_pc   <= 32'd0;
    end else begin
      prev_pc <= debug_wb_pc;
      if (debug_wb_pc != prev_pc)  stall_cnt <= '0;
      else if (state == ST_RUN)    stall_cnt <= stall_cnt + SW'(1);
    end
  end

  assign timeout_hit = (state == ST_RUN) && (debug_wb_pc == prev_pc) &&
                       (stall_cnt == SW'(TIMEOUT - 1));
`else
  // No stall detection in this build; TIMEOUT is referenced only to keep the parameter list uniform.
  assign timeout_hit = (TIMEOUT == 0) & 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= ST_RUN;
      done          <= 1'b0;
      pass          <= 1'b0;
      fail_cause    <= 2'b00;
      err_pc        <= 32'd0;
      err_ref_pc    <= 32'd0;
      err_ref_wdata <= 32'd0;
      err_wdata     <= 32'd0;
      commit_cnt    <= 32'd0;
    end else begin
      state         <= state_next;
      done          <= done_next;
      pass          <= pass_next;
      fail_cause    <= fail_cause_next;
      err_pc        <= err_pc_next;
      err_ref_pc    <= err_ref_pc_next;
      err_ref_wdata <= err_ref_wdata_next;
      err_wdata     <= err_wdata_next;
      commit_cnt    <= commit_cnt_next;
    end
  end

  // Error priority: underrun / mismatch, then timeout, then end-of-run PASS.
  always_comb begin
    state_next         = state;
    done_next          = done;
    pass_next          = pass;
    fail_cause_next    = fail_cause;
    err_pc_next        = err_pc;
    err_ref_pc_next    = err_ref_pc;
    err_ref_wdata_next = err_ref_wdata;
    err_wdata_next     = err_wdata;
    commit_cnt_next    = commit_cnt;
    case (state)
      ST_RUN: begin
        if (pop && !mismatch) commit_cnt_next = commit_cnt + 32'd1;
        if (underrun || mismatch || timeout_hit) begin
          state_next      = ST_FAIL;
          done_next       = 1'b1;
          pass_next       = 1'b0;
          err_pc_next     = debug_wb_pc;
          err_wdata_next  = debug_wb_rf_wdata;
          if (underrun) begin
            fail_cause_next = 2'b10;
          end else if (mismatch) begin
            fail_cause_next    = 2'b01;
            err_ref_pc_next    = head.pc;
            err_ref_wdata_next = head.wdata;
          end else begin
            fail_cause_next = 2'b11;
          end
        end else if (debug_wb_pc == END_PC) begin
          state_next = ST_PASS;
          done_next  = 1'b1;
          pass_next  = 1'b1;
        end
      end
      default: state_next = state;
    endcase
  end

endmodule

// File: tb/tb_trace_wb_checker.sv
// Self-checking bench for trace_wb_checker: directed scenarios plus randomized runs against a queue model.
module tb_trace_wb_checker;
  localparam int unsigned DEPTH   = 16;
  localparam logic [31:0] END_PC  = 32'h1c00_0100;
  localparam int unsigned TIMEOUT = 1024;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_we;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
  logic        ref_valid, ref_ready;
  logic [31:0] ref_pc, ref_wdata;
  logic [4:0]  ref_wnum;
  logic        done, pass;
  logic [1:0]  fail_cause;
  logic [31:0] err_pc, err_ref_pc, err_ref_wdata, err_wdata, commit_cnt;

  trace_wb_checker #(.DEPTH(DEPTH), .END_PC(END_PC), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .resetn(resetn),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
    .ref_valid(ref_valid), .ref_ready(ref_ready),
    .ref_pc(ref_pc), .ref_wnum(ref_wnum), .ref_wdata(ref_wdata),
    .done(done), .pass(pass), .fail_cause(fail_cause),
    .err_pc(err_pc), .err_ref_pc(err_ref_pc), .err_ref_wdata(err_ref_wdata),
    .err_wdata(err_wdata), .commit_cnt(commit_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [4:0] wnum; logic [31:0] wdata; } gold_t;

  // Reference model: the golden trace as a plain queue plus the run verdict.
  gold_t       q[$];
  bit          m_done, m_pass;
  logic [1:0]  m_cause;
  logic [31:0] m_err_pc, m_err_ref_pc, m_err_ref_wdata, m_err_wdata, m_cnt;
  bit          exp_ready;
  logic        seen_ready;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic model_reset();
    q.delete();
    m_done = 0; m_pass = 0; m_cause = 2'b00; m_cnt = 32'd0;
    m_err_pc = 32'd0; m_err_ref_pc = 32'd0; m_err_ref_wdata = 32'd0; m_err_wdata = 32'd0;
  endtask

  task automatic model_step();
    gold_t g;
    bit ok, failed;
    if (m_done) return;
    failed = 0;
    if (debug_wb_rf_we != 4'd0 && debug_wb_rf_wnum != 5'd0) begin
      if (q.size() == 0) begin
        failed = 1; m_cause = 2'b10;
      end else begin
        g = q.pop_front();
        ok = (g.pc == debug_wb_pc) && (g.wnum == debug_wb_rf_wnum);
        for (int b = 0; b < 4; b++)
          if (debug_wb_rf_we[b] && g.wdata[8*b +: 8] != debug_wb_rf_wdata[8*b +: 8]) ok = 0;
        if (ok) m_cnt = m_cnt + 32'd1;
        else begin
          failed = 1; m_cause = 2'b01; m_err_ref_pc = g.pc; m_err_ref_wdata = g.wdata;
        end
      end
    end
    if (failed) begin
      m_done = 1; m_pass = 0; m_err_pc = debug_wb_pc; m_err_wdata = debug_wb_rf_wdata;
    end else if (debug_wb_pc == END_PC) begin
      m_done = 1; m_pass = 1;
    end
    if (exp_ready && ref_valid) q.push_back('{ref_pc, ref_wnum, ref_wdata});
  endtask

  // Called at posedge+1: samples ready, advances one edge, updates the model, settles.
  task automatic tick();
    exp_ready  = !m_done && (q.size() < int'(DEPTH));
    seen_ready = ref_ready;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_idle();
    debug_wb_pc = 32'd0; debug_wb_rf_we = 4'd0; debug_wb_rf_wnum = 5'd0; debug_wb_rf_wdata = 32'd0;
    ref_valid = 1'b0; ref_pc = 32'd0; ref_wnum = 5'd0; ref_wdata = 32'd0;
  endtask

  task automatic set_push(input logic [31:0] pc, input logic [4:0] wn, input logic [31:0] wd);
    ref_valid = 1'b1; ref_pc = pc; ref_wnum = wn; ref_wdata = wd;
  endtask

  task automatic set_commit(input logic [31:0] pc, input logic [3:0] we, input logic [4:0] wn,
                            input logic [31:0] wd);
    debug_wb_pc = pc; debug_wb_rf_we = we; debug_wb_rf_wnum = wn; debug_wb_rf_wdata = wd;
  endtask

  task automatic apply_reset();
    set_idle();
    resetn = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 resetn = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++; if ({done, pass, fail_cause} !== 4'b0000) begin n_bad++;
      $display("FAIL reset_flags: got %b want 0000", {done, pass, fail_cause}); end
    n_cmp++; if ({err_pc, err_ref_pc, err_ref_wdata, err_wdata, commit_cnt} !== 160'd0) begin n_bad++;
      $display("FAIL reset_err_cnt: got %h want 0", {err_pc, err_ref_pc, err_ref_wdata, err_wdata, commit_cnt}); end
    n_cmp++; if (ref_ready !== 1'b1) begin n_bad++;
      $display("FAIL reset_ready: got %b want 1", ref_ready); end
  endtask

  task automatic test_pass_run();
    apply_reset();
    set_push(32'h1c00_0000, 5'd1, 32'h5); tick();
    set_push(32'h1c00_0004, 5'd2, 32'h7); tick();
    set_push(32'h1c00_0008, 5'd3, 32'hC); tick();
    set_idle();
    set_commit(32'h1c00_0000, 4'hF, 5'd1, 32'h5); tick();
    set_commit(32'h1c00_0004, 4'hF, 5'd2, 32'h7); tick();
    set_commit(32'h1c00_0008, 4'hF, 5'd3, 32'hC); tick();
    n_cmp++; if ({done, commit_cnt} !== {1'b0, 32'd3}) begin n_bad++;
      $display("FAIL pass_pre_end: got done=%b cnt=%0d want done=0 cnt=3", done, commit_cnt); end
    set_idle(); debug_wb_pc = END_PC; tick();
    n_cmp++; if ({done, pass, fail_cause} !== 4'b1100) begin n_bad++;
      $display("FAIL pass_flags: got %b want 1100", {done, pass, fail_cause}); end
    n_cmp++; if (commit_cnt !== 32'd3) begin n_bad++;
      $display("FAIL pass_cnt: got %0d want 3", commit_cnt); end
  endtask

  task automatic test_mismatch();
    apply_reset();
    set_push(32'h1c00_0000, 5'd4, 32'h1234_5678); tick();
    set_idle(); set_commit(32'h1c00_0000, 4'hF, 5'd4, 32'h1234_5679); tick();
    n_cmp++; if ({done, pass, fail_cause} !== 4'b1001) begin n_bad++;
      $display("FAIL mism_flags: got %b want 1001", {done, pass, fail_cause}); end
    n_cmp++; if ({err_ref_pc, err_ref_wdata} !== {32'h1c00_0000, 32'h1234_5678}) begin n_bad++;
      $display("FAIL mism_ref: got %h %h want 1c000000 12345678", err_ref_pc, err_ref_wdata); end
    n_cmp++; if ({err_pc, err_wdata} !== {32'h1c00_0000, 32'h1234_5679}) begin n_bad++;
      $display("FAIL mism_dut: got %h %h want 1c000000 12345679", err_pc, err_wdata); end
    set_idle(); debug_wb_pc = END_PC; tick();
    n_cmp++; if ({seen_ready, done, pass, fail_cause} !== 5'b01001) begin n_bad++;
      $display("FAIL mism_sticky: got %b want 01001", {seen_ready, done, pass, fail_cause}); end
  endtask

  task automatic test_byte_mask();
    apply_reset();
    set_push(32'h1c00_0040, 5'd5, 32'hAABB_CC11); tick();
    set_push(32'h1c00_0044, 5'd6, 32'h0000_0055); tick();
    set_idle(); set_commit(32'h1c00_0040, 4'b0001, 5'd5, 32'h0000_0011); tick();
    n_cmp++; if ({done, commit_cnt} !== {1'b0, 32'd1}) begin n_bad++;
      $display("FAIL mask_match: got done=%b cnt=%0d want 0 1", done, commit_cnt); end
    set_commit(32'h1c00_0044, 4'b0001, 5'd0, 32'hDEAD_BEEF); tick();
    set_commit(32'h1c00_0048, 4'b0000, 5'd9, 32'hDEAD_BEEF); tick();
    n_cmp++; if ({done, commit_cnt} !== {1'b0, 32'd1}) begin n_bad++;
      $display("FAIL mask_ignored: got done=%b cnt=%0d want 0 1", done, commit_cnt); end
    set_commit(32'h1c00_0044, 4'hF, 5'd6, 32'h0000_0055); tick();
    n_cmp++; if ({done, commit_cnt} !== {1'b0, 32'd2}) begin n_bad++;
      $display("FAIL mask_head_kept: got done=%b cnt=%0d want 0 2", done, commit_cnt); end
  endtask

  task automatic test_underrun_full();
    apply_reset();
    set_push(32'h1c00_0000, 5'd1, 32'h1); set_commit(32'h1c00_0000, 4'hF, 5'd1, 32'h1); tick();
    n_cmp++; if ({done, pass, fail_cause, err_ref_pc} !== {4'b1010, 32'd0}) begin n_bad++;
      $display("FAIL underrun_nobypass: got %b ref_pc=%h want 1010 0", {done, pass, fail_cause}, err_ref_pc); end
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      set_push(32'h1c02_0000 + 32'(i * 4), 5'(i + 1), 32'(i * 3 + 1)); tick();
    end
    n_cmp++; if (ref_ready !== 1'b0) begin n_bad++;
      $display("FAIL full_ready: got %b want 0", ref_ready); end
    set_push(32'h1c02_0100, 5'd20, 32'hFFFF_FFFF);
    set_commit(32'h1c02_0000, 4'hF, 5'd1, 32'd1); tick();
    n_cmp++; if ({seen_ready, ref_ready, commit_cnt} !== {2'b01, 32'd1}) begin n_bad++;
      $display("FAIL full_pop: got ready %b->%b cnt=%0d want 0->1 1", seen_ready, ref_ready, commit_cnt); end
    set_idle();
    for (int i = 1; i < 16; i++) begin
      set_commit(32'h1c02_0000 + 32'(i * 4), 4'hF, 5'(i + 1), 32'(i * 3 + 1)); tick();
    end
    n_cmp++; if ({done, commit_cnt} !== {1'b0, 32'd16}) begin n_bad++;
      $display("FAIL full_drain: got done=%b cnt=%0d want 0 16", done, commit_cnt); end
    set_commit(32'h1c02_0100, 4'hF, 5'd20, 32'hFFFF_FFFF); tick();
    n_cmp++; if (fail_cause !== 2'b10) begin n_bad++;
      $display("FAIL full_no_extra_push: got cause=%b want 10", fail_cause); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    set_push(32'h1c00_0000, 5'd7, 32'h77); tick();
    set_idle(); set_commit(32'h1c00_0000, 4'hF, 5'd7, 32'h78); tick();
    set_idle();
    #2 resetn = 1'b0;
    #1;
    n_cmp++; if ({done, pass, fail_cause, err_pc, err_ref_pc, err_ref_wdata, err_wdata, commit_cnt} !== 164'd0) begin n_bad++;
      $display("FAIL async_clear: got done=%b cause=%b err_pc=%h", done, fail_cause, err_pc); end
    @(posedge clk);
    #2 resetn = 1'b1;
    #1;
    n_cmp++; if (ref_ready !== 1'b1) begin n_bad++;
      $display("FAIL async_ready: got %b want 1", ref_ready); end
    model_reset();
    @(posedge clk);
    #1;
    set_push(32'h1c00_0020, 5'd8, 32'h88); tick();
    set_idle(); set_commit(32'h1c00_0020, 4'hF, 5'd8, 32'h88); tick();
    set_idle(); debug_wb_pc = END_PC; tick();
    n_cmp++; if ({done, pass, fail_cause, commit_cnt} !== {4'b1100, 32'd1}) begin n_bad++;
      $display("FAIL async_rerun: got %b cnt=%0d want 1100 1", {done, pass, fail_cause}, commit_cnt); end
  endtask

  task automatic test_timeout();
    int waited;
    apply_reset();
    set_idle(); debug_wb_pc = 32'h1c00_0010;
    for (int i = 0; i < 1000; i++) tick();
    n_cmp++; if (done !== 1'b0) begin n_bad++;
      $display("FAIL timeout_early: got done=%b want 0", done); end
`ifdef TRACE_CHK_TIMEOUT_EN
    waited = 0;
    while (done !== 1'b1 && waited < 200) begin tick(); waited++; end
    n_cmp++; if ({done, pass, fail_cause, err_pc} !== {4'b1011, 32'h1c00_0010}) begin n_bad++;
      $display("FAIL timeout_hit: got %b err_pc=%h want 1011 1c000010", {done, pass, fail_cause}, err_pc); end
`else
    waited = 0;
    repeat (200) begin tick(); waited++; end
    n_cmp++; if ({done, fail_cause} !== 3'b000) begin n_bad++;
      $display("FAIL timeout_absent: got %b after %0d more cycles want 000", {done, fail_cause}, waited); end
`endif
  endtask

  task automatic test_random();
    gold_t g;
    int r, post;
    for (int run = 0; run < 30; run++) begin
      apply_reset();
      post = 0;
      for (int cyc = 0; cyc < 60 && post < 3; cyc++) begin
        r = $urandom_range(0, 99);
        ref_valid = ($urandom_range(0, 2) != 0);
        ref_pc    = 32'h1c01_0000 + 32'($urandom_range(0, 255)) * 32'd4;
        ref_wnum  = 5'($urandom_range(1, 31));
        ref_wdata = $urandom();
        set_commit(32'h1c03_0000 + 32'($urandom_range(0, 255)) * 32'd4, 4'd0,
                   5'($urandom_range(0, 31)), $urandom());
        if (r < 50 && q.size() > 0) begin
          g = q[0];
          set_commit(g.pc, 4'($urandom_range(1, 15)), g.wnum, g.wdata);
          for (int b = 0; b < 4; b++)
            if (!debug_wb_rf_we[b]) debug_wb_rf_wdata[8*b +: 8] = 8'($urandom());
          case ($urandom_range(0, 11))
            0: debug_wb_pc = g.pc ^ 32'h4;
            1: debug_wb_rf_wnum = (g.wnum == 5'd31) ? 5'd1 : g.wnum + 5'd1;
            2: debug_wb_rf_wdata = debug_wb_rf_wdata ^ (32'($urandom_range(1, 255)) << (8 * $urandom_range(0, 3)));
            default: ;
          endcase
        end else if (r < 56) begin
          debug_wb_rf_we = 4'($urandom_range(1, 15));
        end else if (r < 60) begin
          debug_wb_rf_we = 4'($urandom_range(1, 15)); debug_wb_rf_wnum = 5'd0;
        end else if (r < 63) begin
          debug_wb_pc = END_PC;
        end
        tick();
        n_cmp++; if (seen_ready !== logic'(exp_ready)) begin n_bad++;
          $display("FAIL rnd_ready run%0d cyc%0d: got %b want %b", run, cyc, seen_ready, exp_ready); end
        n_cmp++; if ({done, pass, fail_cause} !== {m_done, m_pass, m_cause}) begin n_bad++;
          $display("FAIL rnd_flags run%0d cyc%0d: got %b want %b", run, cyc, {done, pass, fail_cause}, {m_done, m_pass, m_cause}); end
        n_cmp++; if (commit_cnt !== m_cnt) begin n_bad++;
          $display("FAIL rnd_cnt run%0d cyc%0d: got %0d want %0d", run, cyc, commit_cnt, m_cnt); end
        n_cmp++; if ({err_pc, err_ref_pc, err_ref_wdata, err_wdata} !== {m_err_pc, m_err_ref_pc, m_err_ref_wdata, m_err_wdata}) begin n_bad++;
          $display("FAIL rnd_err run%0d cyc%0d: got %h want %h", run, cyc,
                   {err_pc, err_ref_pc, err_ref_wdata, err_wdata}, {m_err_pc, m_err_ref_pc, m_err_ref_wdata, m_err_wdata}); end
        if (m_done) post++;
      end
    end
  endtask

  initial begin
    resetn = 1'b0;
    set_idle();
    model_reset();
    test_reset();
    test_pass_run();
    test_mismatch();
    test_byte_mask();
    test_underrun_full();
    test_async_reset();
    test_random();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
